// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
//   Shared definitions for the pipelined carry-lookahead adder.
//   - GROUP_W     : width of one carry-lookahead group (fixed at 4 bits)
//   - stage_ctl_t : per-stage record of slot valid flag and registered carry
//   - cfg_ok()    : elaboration-time legality check for WIDTH/STAGES
//   No ports (package). No configuration macros.
// -----------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W = 4;

    // One pipeline slot's control state: whether the slot holds a live
    // operation, and the carry out of the slice that stage just added.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    // WIDTH must split into STAGES equal slices, each a whole number of
    // 4-bit groups, and STAGES must be at least 1.
    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) &&
               (width >= GROUP_W) &&
               (stages <= width / GROUP_W) &&
               ((width % (GROUP_W * stages)) == 0);
    endfunction

endpackage : cla_pkg

// File: rtl/cla4_group.sv
// -----------------------------------------------------------------------------
// cla4_group
//   Purely combinational 4-bit carry-lookahead group.
//   Ports:
//     a, b   [3:0]  in   operand bits of this group
//     cin           in   carry into bit 0 of the group
//     s      [3:0]  out  sum bits
//     cout          out  carry out of bit 3
//     grp_p         out  group propagate (all four bits propagate)
//     grp_g         out  group generate (group produces a carry on its own)
//   No configuration macros.
// -----------------------------------------------------------------------------
module cla4_group
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               cin,
    output logic [GROUP_W-1:0] s,
    output logic               cout,
    output logic               grp_p,
    output logic               grp_g
);

    logic [GROUP_W-1:0] prop;
    logic [GROUP_W-1:0] gen;
    logic [GROUP_W:0]   c;

    assign prop = a ^ b;
    assign gen  = a & b;

    // Internal carries are flattened two-level lookahead terms, no ripple.
    assign c[0] = cin;
    assign c[1] = gen[0] | (prop[0] & cin);
    assign c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    assign c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                | (prop[2] & prop[1] & prop[0] & cin);

    assign grp_p = &prop;
    assign grp_g = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0]);

    assign c[4] = grp_g | (grp_p & cin);
    assign cout = c[4];

    assign s = prop ^ c[GROUP_W-1:0];

endmodule : cla4_group

// File: rtl/cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined WIDTH-bit carry-lookahead adder. The add is split into STAGES
//   equal slices; stage k adds slice k with 4-bit CLA groups (rippling group
//   to group inside the stage) and registers its carry for stage k+1.
//   Latency STAGES cycles, throughput one operation per cycle.
//
//   Ports:
//     clk        in   clock, rising edge
//     reset_n    in   asynchronous active-low reset
//     in_valid   in   operand set valid
//     in_ready   out  operands accepted this cycle if in_valid
//     a, b       in   operands [WIDTH-1:0]
//     ci         in   carry-in
//     sub        in   subtract select (only with CLA_PIPE_SUB_EN)
//     out_valid  out  result valid
//     out_ready  in   downstream accepts result
//     s          out  sum [WIDTH-1:0], modulo 2^WIDTH
//     co         out  carry out of the MSB (with sub: 1 = no borrow)
//     ovf        out  two's-complement signed overflow
//
//   Configuration macro:
//     CLA_PIPE_SUB_EN  adds the sub port; sub=1 computes a - b as a + ~b + 1
//                      (ci is ignored while sub=1).
//
//   Handshake: a transfer happens on a side only in a cycle where its valid
//   and ready are both 1. The pipeline advances as one unit whenever the
//   output slot is empty or being drained (advance = out_ready | !out_valid);
//   in_ready equals advance and never looks at in_valid, so there is no
//   combinational path from in_valid to in_ready.
// -----------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef CLA_PIPE_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int SW  = WIDTH / STAGES;   // bits added per stage
    localparam int NG  = SW / GROUP_W;     // CLA groups per stage
    localparam int MSB = WIDTH - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("cla_pipe_adder: WIDTH must be a multiple of 4*STAGES and STAGES in 1..WIDTH/4");
    end

    // Effective operands: subtraction is folded in at the input so every
    // stage only ever adds.
    logic [WIDTH-1:0] b_eff;
    logic             ci_eff;

`ifdef CLA_PIPE_SUB_EN
    assign b_eff  = sub ? ~b : b;
    assign ci_eff = sub ? 1'b1 : ci;
`else
    assign b_eff  = b;
    assign ci_eff = ci;
`endif

    // Slot k registers. Operands travel full width so slice k+1.. is still
    // available to later stages (operand skew); s_q[k] carries the slices
    // finished so far so all slices leave together (result de-skew).
    stage_ctl_t       ctl_q [STAGES];
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] b_q   [STAGES];
    logic [WIDTH-1:0] s_q   [STAGES];
    logic             ovf_q;

    // Per-stage combinational inputs and results.
    logic [WIDTH-1:0] st_a     [STAGES];
    logic [WIDTH-1:0] st_b     [STAGES];
    logic [WIDTH-1:0] st_s_in  [STAGES];
    logic [WIDTH-1:0] st_s_out [STAGES];
    logic             st_c_in  [STAGES];
    logic             st_v_in  [STAGES];
    logic             st_co    [STAGES];
    logic             ovf_next;
    logic             advance;

    assign advance   = out_ready || !out_valid;
    assign in_ready  = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;
        localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({SW{1'b1}}) << LO;

        logic [SW-1:0] slice_s;
        logic [NG:0]   c;
        logic [NG-1:0] grp_co;
        logic [NG-1:0] grp_p;
        logic [NG-1:0] grp_g;

        if (k == 0) begin : g_head
            assign st_a[k]    = a;
            assign st_b[k]    = b_eff;
            assign st_s_in[k] = '0;
            assign st_c_in[k] = ci_eff;
            assign st_v_in[k] = in_valid;
        end else begin : g_body
            assign st_a[k]    = a_q[k-1];
            assign st_b[k]    = b_q[k-1];
            assign st_s_in[k] = s_q[k-1];
            assign st_c_in[k] = ctl_q[k-1].carry;
            assign st_v_in[k] = ctl_q[k-1].valid;
        end

        assign c[0] = st_c_in[k];

        for (genvar g = 0; g < NG; g++) begin : g_grp
            cla4_group u_grp (
                .a     (st_a[k][LO+g*GROUP_W +: GROUP_W]),
                .b     (st_b[k][LO+g*GROUP_W +: GROUP_W]),
                .cin   (c[g]),
                .s     (slice_s[g*GROUP_W +: GROUP_W]),
                .cout  (grp_co[g]),
                .grp_p (grp_p[g]),
                .grp_g (grp_g[g])
            );
        end

        // Groups ripple into each other inside the stage.
        assign c[NG:1]     = grp_co;
        assign st_co[k]    = c[NG];
        assign st_s_out[k] = (st_s_in[k] & ~SLICE_MASK) | (WIDTH'(slice_s) << LO);

        // Each group's carry-out must agree with its own lookahead terms.
        a_group_carry : assert property (@(posedge clk) disable iff (!reset_n)
            grp_co == (grp_g | (grp_p & c[NG-1:0])));
    end

    // Carry into the MSB is recovered from the MSB sum bit: a ^ b ^ s.
    assign ovf_next = st_a[STAGES-1][MSB] ^ st_b[STAGES-1][MSB]
                    ^ st_s_out[STAGES-1][MSB] ^ st_co[STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            // Whole pipe shifts together; a bubble just loads valid=0.
            for (int k = 0; k < STAGES; k++) begin
                ctl_q[k] <= stage_ctl_t'{valid: st_v_in[k], carry: st_co[k]};
                a_q[k]   <= st_a[k];
                b_q[k]   <= st_b[k];
                s_q[k]   <= st_s_out[k];
            end
            ovf_q <= ovf_next;
        end
    end

    assign out_valid = ctl_q[STAGES-1].valid;
    assign co        = ctl_q[STAGES-1].carry;
    assign s         = s_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule : cla_pipe_adder

// File: tb/tb_cla_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Directed-vector bench for cla_pipe_adder (WIDTH=32, STAGES=2). Expected
//   results are pushed into a queue when an operand set is accepted; an
//   independent monitor pops and compares whenever a result is transferred.
//   Inputs change on the falling edge; everything is sampled 3 time units
//   after the falling edge, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_cla_pipe_adder;

    localparam int W = 32;
    localparam int S = 2;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    cla_pipe_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
`ifdef CLA_PIPE_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    // ---------------- scoreboard state ----------------
    logic [W+1:0] exp_q[$];   // {co, ovf, s}
    int           acc_q[$];   // cycle in which the operand set was accepted
    int           lat_q[$];   // required latency, 0 = not checked (stalled)
    int           total = 0;
    int           bad   = 0;
    int           push_n = 0;
    int           pop_n  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv,
                        input logic [W-1:0] es, input logic eco, input logic eovf,
                        input int elat);
        bit done;
        done     = 1'b0;
        a        = av;
        b        = bv;
        ci       = cv;
        sub      = sv;
        in_valid = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            #3;
            if (in_ready) begin
                exp_q.push_back({eco, eovf, es});
                acc_q.push_back(cyc);
                lat_q.push_back(elat);
                push_n++;
                done = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: operand a=0x%0h not accepted within 50 cycles", av);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // ---------------- monitor ----------------
    logic [W+1:0] mon_e;
    int           mon_acc;
    int           mon_lat;

    always @(negedge clk) begin
        #3;
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got s=0x%0h, expected no output", s);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_acc = acc_q.pop_front();
                mon_lat = lat_q.pop_front();
                pop_n++;
                check("sum", s, mon_e[W-1:0]);
                check("carry_out", co, mon_e[W+1]);
                check("overflow", ovf, mon_e[W]);
                if (mon_lat > 0) check("latency", cyc - mon_acc, mon_lat);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    bit saw_valid;

    initial begin
        // Reset held with random activity on the inputs.
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        a         = $urandom;
        b         = $urandom;
        ci        = 1'($urandom_range(0, 1));
        sub       = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        repeat (3) begin
            @(negedge clk);
            a         = $urandom;
            b         = $urandom;
            ci        = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
        end
        #3;
        check("reset_out_valid", out_valid, 0);
        check("reset_s", s, 0);
        check("reset_co", co, 0);
        check("reset_ovf", ovf, 0);
        check("reset_in_ready", in_ready, 1);

        @(negedge clk);
        in_valid  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        reset_n   = 1'b1;
        @(negedge clk);

        // Wrap-around, signed overflow both ways, inter-stage carry, ci path.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 2);
        drain();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 2);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 2);
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 32'h2143_6588, 1'b0, 1'b0, 2);
        send(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 2);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 2);
        drain();

        // Backpressure: pipe fills to 2 entries, then drains in order.
        out_ready = 1'b0;
        fork
            begin
                send(32'd1, 32'd1, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0, 0);
                send(32'd2, 32'd2, 1'b0, 1'b0, 32'd4, 1'b0, 1'b0, 0);
                send(32'd3, 32'd3, 1'b0, 1'b0, 32'd6, 1'b0, 1'b0, 0);
                send(32'd4, 32'd4, 1'b0, 1'b0, 32'd8, 1'b0, 1'b0, 0);
            end
            begin
                repeat (4) @(negedge clk);
                #3;
                check("stall_in_ready", in_ready, 0);
                check("stall_out_valid", out_valid, 1);
                check("stall_head_sum", s, 32'd2);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        check("stall_result_count", pop_n, push_n);

        // Reset pulse with two operations in flight.
        out_ready = 1'b0;
        send(32'd10, 32'd10, 1'b0, 1'b0, 32'd20, 1'b0, 1'b0, 0);
        send(32'd11, 32'd11, 1'b0, 1'b0, 32'd22, 1'b0, 1'b0, 0);
        #1;
        check("preflush_out_valid", out_valid, 1);
        reset_n = 1'b0;
        #1;
        check("flush_out_valid", out_valid, 0);
        check("flush_s", s, 0);
        check("flush_in_ready", in_ready, 1);
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        push_n = 0;
        pop_n  = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        saw_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            #3;
            if (out_valid) saw_valid = 1'b1;
        end
        check("post_flush_idle", saw_valid, 0);
        @(negedge clk);
        send(32'd9, 32'd9, 1'b0, 1'b0, 32'd18, 1'b0, 1'b0, 2);
        drain();

`ifdef CLA_PIPE_SUB_EN
        send(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 2);
        send(32'd7, 32'd5, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 2);
        drain();
`endif

        check("final_result_count", pop_n, push_n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cla_pipe_adder
